// File: rtl/exec_pkg.sv
// Shared types and field positions for the exec_unit8 execute stage.
// The optional ADDC carry chain is enabled by defining EXEC_CARRY_CHAIN_EN.
package exec_pkg;

    localparam int INSTR_W     = 19;
    localparam int DATA_W      = 8;
    localparam int REG_AW      = 3;
    localparam int OP_MSB      = 18;
    localparam int IMM_SEL_BIT = 15;
    localparam int RD_LSB      = 12;
    localparam int RS1_LSB     = 9;
    localparam int RS2_LSB     = 6;

    typedef enum logic [2:0] {
        OP_AND   = 3'b000,
        OP_OR    = 3'b001,
        OP_XOR   = 3'b010,
        OP_NOT   = 3'b011,
        OP_ADD   = 3'b100,
        OP_ADDC  = 3'b101,
        OP_LOADI = 3'b110,
        OP_HALT  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        WB    = 2'd2,
        HALT  = 2'd3
    } state_e;

    function automatic logic is_arith(input op_e op);
        return (op == OP_ADD) || (op == OP_ADDC);
    endfunction

endpackage

// File: rtl/exec_regfile.sv
// NREGS x 8 register file: two combinational read ports, one synchronous
// write port, R0 hardwired to zero, synchronous clear.
module exec_regfile
    import exec_pkg::*;
#(
    parameter int NREGS = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [REG_AW-1:0] raddr_a,
    input  logic [REG_AW-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata
);

    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    logic [AW-1:0] idx_a;
    logic [AW-1:0] idx_b;
    logic [AW-1:0] idx_w;

    assign idx_a = raddr_a[AW-1:0];
    assign idx_b = raddr_b[AW-1:0];
    assign idx_w = waddr[AW-1:0];

    assign rdata_a = (idx_a == '0) ? '0 : regs_q[idx_a];
    assign rdata_b = (idx_b == '0) ? '0 : regs_q[idx_b];

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign regs_d[gi] = '0;
            end else begin : g_data
                assign regs_d[gi] = (we && (idx_w == AW'(gi))) ? wdata : regs_q[gi];
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

endmodule

// File: rtl/exec_unit8.sv
// Three-cycle FETCH/EXEC/WB execute stage with inline 8-bit ALU and flags.
// Define EXEC_CARRY_CHAIN_EN to feed carry_flag into ADDC; otherwise ADDC == ADD.
module exec_unit8
    import exec_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int CNT_W = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    output logic [DATA_W-1:0]  wb_data,
    output logic [REG_AW-1:0]  wb_addr,
    output logic               zero_flag,
    output logic               carry_flag,
    output logic               halted,
    output logic [CNT_W-1:0]   retire_cnt
);

    state_e             state_q,  state_d;
    logic [INSTR_W-1:0] ir_q,     ir_d;
    logic [DATA_W:0]    res_q,    res_d;
    logic [DATA_W-1:0]  wb_data_q, wb_data_d;
    logic [REG_AW-1:0]  wb_addr_q, wb_addr_d;
    logic               zero_q,   zero_d;
    logic               carry_q,  carry_d;
    logic               halted_q, halted_d;
    logic               ready_q,  ready_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;

    op_e               op;
    logic              imm_sel;
    logic [REG_AW-1:0] rd, rs1, rs2;
    logic [DATA_W-1:0] imm8;
    logic [DATA_W-1:0] rdata_a, rdata_b;
    logic [DATA_W-1:0] opa, opb;
    logic              cin;
    logic [DATA_W:0]   alu_res;
    logic              rf_we;

    assign op      = op_e'(ir_q[OP_MSB -: 3]);
    assign imm_sel = ir_q[IMM_SEL_BIT];
    assign rd      = ir_q[RD_LSB +: REG_AW];
    assign rs1     = ir_q[RS1_LSB +: REG_AW];
    assign rs2     = ir_q[RS2_LSB +: REG_AW];
    assign imm8    = ir_q[DATA_W-1:0];

    // Write happens in WB from the result latched during EXEC; R0 filtering is in the regfile.
    assign rf_we = (state_q == WB);

    exec_regfile #(
        .NREGS (NREGS)
    ) u_regfile (
        .clock   (clock),
        .reset   (reset),
        .raddr_a (rs1),
        .raddr_b (rs2),
        .rdata_a (rdata_a),
        .rdata_b (rdata_b),
        .we      (rf_we),
        .waddr   (rd),
        .wdata   (res_q[DATA_W-1:0])
    );

    assign opa = rdata_a;
    assign opb = imm_sel ? imm8 : rdata_b;

    always_comb begin
        cin = 1'b0;
`ifdef EXEC_CARRY_CHAIN_EN
        if (op == OP_ADDC) begin
            cin = carry_q;
        end
`else
        cin = 1'b0;
`endif
        alu_res = '0;
        case (op)
            OP_AND:          alu_res = {1'b0, opa & opb};
            OP_OR:           alu_res = {1'b0, opa | opb};
            OP_XOR:          alu_res = {1'b0, opa ^ opb};
            OP_NOT:          alu_res = {1'b0, ~opa};
            OP_ADD, OP_ADDC: alu_res = {1'b0, opa} + {1'b0, opb} + {{DATA_W{1'b0}}, cin};
            OP_LOADI:        alu_res = {1'b0, imm8};
            default:         alu_res = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        res_d     = res_q;
        wb_data_d = wb_data_q;
        wb_addr_d = wb_addr_q;
        zero_d    = zero_q;
        carry_d   = carry_q;
        halted_d  = halted_q;
        ready_d   = 1'b0;
        cnt_d     = cnt_q;
        case (state_q)
            FETCH: begin
                if (instr_valid) begin
                    ir_d    = instr;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                res_d = alu_res;
                if (op == OP_HALT) begin
                    state_d  = HALT;
                    halted_d = 1'b1;
                end else begin
                    state_d = WB;
                end
            end
            WB: begin
                wb_data_d = res_q[DATA_W-1:0];
                wb_addr_d = rd;
                zero_d    = (res_q[DATA_W-1:0] == '0);
                if (is_arith(op)) begin
                    carry_d = res_q[DATA_W];
                end
                ready_d = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = FETCH;
            end
            default: begin
                state_d = HALT;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= FETCH;
            ir_q      <= '0;
            res_q     <= '0;
            wb_data_q <= '0;
            wb_addr_q <= '0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
            halted_q  <= 1'b0;
            ready_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            res_q     <= res_d;
            wb_data_q <= wb_data_d;
            wb_addr_q <= wb_addr_d;
            zero_q    <= zero_d;
            carry_q   <= carry_d;
            halted_q  <= halted_d;
            ready_q   <= ready_d;
            cnt_q     <= cnt_d;
        end
    end

    assign instr_ready = ready_q;
    assign wb_data     = wb_data_q;
    assign wb_addr     = wb_addr_q;
    assign zero_flag   = zero_q;
    assign carry_flag  = carry_q;
    assign halted      = halted_q;
    assign retire_cnt  = cnt_q;

endmodule

// File: tb/tb_exec_unit8.sv
// Directed self-checking bench for exec_unit8 with hand-computed expectations.
module tb_exec_unit8;

    logic        clock = 1'b0;
    logic        reset;
    logic [18:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  wb_data;
    logic [2:0]  wb_addr;
    logic        zero_flag;
    logic        carry_flag;
    logic        halted;
    logic [7:0]  retire_cnt;

    int passed  = 0;
    int total   = 0;
    int exp_cnt = 0;

    always #5 clock = ~clock;

    exec_unit8 #(
        .NREGS (8),
        .CNT_W (8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .wb_data     (wb_data),
        .wb_addr     (wb_addr),
        .zero_flag   (zero_flag),
        .carry_flag  (carry_flag),
        .halted      (halted),
        .retire_cnt  (retire_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    function automatic logic [18:0] rr(input logic [2:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs1, input logic [2:0] rs2);
        return {op, 1'b0, rd, rs1, rs2, 6'b0};
    endfunction

    function automatic logic [18:0] ri(input logic [2:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs1, input logic [7:0] imm);
        return {op, 1'b1, rd, rs1, 1'b0, imm};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one word for exactly one sample, then scramble instr to prove IR latching.
    task automatic issue(input logic [18:0] w, input string name);
        instr       = w;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        instr       = 19'h7FFFF;
        chk({name, "_ready_exec"}, {31'd0, instr_ready}, 32'd0);
        tick();
        tick();
        exp_cnt++;
        $display("issue %-10s word=%05h wb_addr=%0d wb_data=%02h z=%0b c=%0b cnt=%0d",
                 name, w, wb_addr, wb_data, zero_flag, carry_flag, retire_cnt);
    endtask

    task automatic expect_wb(input string name, input logic [2:0] a, input logic [7:0] d,
                             input logic z, input logic c);
        chk({name, "_ready"}, {31'd0, instr_ready}, 32'd1);
        chk({name, "_addr"},  {29'd0, wb_addr}, {29'd0, a});
        chk({name, "_data"},  {24'd0, wb_data}, {24'd0, d});
        chk({name, "_zero"},  {31'd0, zero_flag}, {31'd0, z});
        chk({name, "_carry"}, {31'd0, carry_flag}, {31'd0, c});
        chk({name, "_cnt"},   {24'd0, retire_cnt}, exp_cnt & 32'hFF);
    endtask

    task automatic expect_all_zero(input string name);
        chk({name, "_ready"},  {31'd0, instr_ready}, 32'd0);
        chk({name, "_data"},   {24'd0, wb_data}, 32'd0);
        chk({name, "_addr"},   {29'd0, wb_addr}, 32'd0);
        chk({name, "_zero"},   {31'd0, zero_flag}, 32'd0);
        chk({name, "_carry"},  {31'd0, carry_flag}, 32'd0);
        chk({name, "_halted"}, {31'd0, halted}, 32'd0);
        chk({name, "_cnt"},    {24'd0, retire_cnt}, 32'd0);
    endtask

    logic [7:0] addc_exp;

    initial begin
        reset       = 1'b1;
        instr       = '0;
        instr_valid = 1'b0;
`ifdef EXEC_CARRY_CHAIN_EN
        addc_exp = 8'h01;
`else
        addc_exp = 8'h00;
`endif
        tick();
        tick();
        expect_all_zero("reset");
        reset = 1'b0;

        issue(19'b110_0_001_000_0_0011_1100, "LOADI_R1");
        expect_wb("loadi_r1", 3'd1, 8'h3C, 1'b0, 1'b0);
        issue(ri(3'b110, 3'd2, 3'd0, 8'h0F), "LOADI_R2");
        expect_wb("loadi_r2", 3'd2, 8'h0F, 1'b0, 1'b0);

        issue(rr(3'b000, 3'd3, 3'd1, 3'd2), "AND_R3");
        expect_wb("and", 3'd3, 8'h0C, 1'b0, 1'b0);
        issue(rr(3'b001, 3'd3, 3'd1, 3'd2), "OR_R3");
        expect_wb("or", 3'd3, 8'h3F, 1'b0, 1'b0);
        issue(rr(3'b010, 3'd3, 3'd1, 3'd2), "XOR_R3");
        expect_wb("xor", 3'd3, 8'h33, 1'b0, 1'b0);
        issue(rr(3'b011, 3'd4, 3'd1, 3'd2), "NOT_R4");
        expect_wb("not", 3'd4, 8'hC3, 1'b0, 1'b0);

        issue(ri(3'b100, 3'd5, 3'd1, 8'hC4), "ADD_R5");
        expect_wb("add_wrap", 3'd5, 8'h00, 1'b1, 1'b1);
        issue(rr(3'b010, 3'd7, 3'd1, 3'd1), "XOR_R7");
        expect_wb("xor_keepc", 3'd7, 8'h00, 1'b1, 1'b1);
        issue(ri(3'b101, 3'd6, 3'd0, 8'h00), "ADDC_R6");
        expect_wb("addc", 3'd6, addc_exp, (addc_exp == 8'h00), 1'b0);

        issue(ri(3'b110, 3'd0, 3'd0, 8'h55), "LOADI_R0");
        expect_wb("loadi_r0", 3'd0, 8'h55, 1'b0, 1'b0);
        issue(rr(3'b001, 3'd7, 3'd0, 3'd0), "OR_R0R0");
        expect_wb("r0_reads0", 3'd7, 8'h00, 1'b1, 1'b0);
        issue(rr(3'b001, 3'd7, 3'd3, 3'd0), "OR_R3R0");
        expect_wb("raw_r3", 3'd7, 8'h33, 1'b0, 1'b0);
        issue(rr(3'b100, 3'd1, 3'd4, 3'd6), "ADD_R4R6");
        expect_wb("add_regreg", 3'd1, 8'hC3 + addc_exp, 1'b0, 1'b0);

        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_ready", {31'd0, instr_ready}, 32'd0);
            chk("idle_cnt", {24'd0, retire_cnt}, exp_cnt & 32'hFF);
        end
        $display("idle 5 cycles cnt=%0d", retire_cnt);

        // Reset lands on the EXEC cycle of an ADD; nothing may be written back.
        instr       = ri(3'b100, 3'd5, 3'd1, 8'h01);
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        reset       = 1'b1;
        tick();
        reset = 1'b0;
        expect_all_zero("midreset");
        tick();
        expect_all_zero("midreset_hold");
        exp_cnt = 0;
        $display("reset during EXEC of ADD_R5");

        issue(ri(3'b110, 3'd2, 3'd0, 8'h81), "LOADI_R2b");
        expect_wb("post_reset", 3'd2, 8'h81, 1'b0, 1'b0);
        issue(rr(3'b100, 3'd3, 3'd2, 3'd2), "ADD_R3");
        expect_wb("add_carry", 3'd3, 8'h02, 1'b0, 1'b1);
        issue(rr(3'b001, 3'd4, 3'd1, 3'd0), "OR_R1clr");
        expect_wb("regs_cleared", 3'd4, 8'h00, 1'b1, 1'b1);

        for (int i = 3; i < 256; i++) begin
            issue(ri(3'b110, 3'd1, 3'd0, 8'(i)), "LOADI_LOOP");
        end
        expect_wb("cnt_wrap", 3'd1, 8'hFF, 1'b0, 1'b1);

        // HALT with instr_valid held high: nothing may retire afterwards.
        instr       = {3'b111, 16'h0};
        instr_valid = 1'b1;
        tick();
        tick();
        instr = ri(3'b110, 3'd1, 3'd0, 8'h11);
        $display("issue HALT");
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("halt_halted", {31'd0, halted}, 32'd1);
            chk("halt_ready", {31'd0, instr_ready}, 32'd0);
            chk("halt_cnt", {24'd0, retire_cnt}, exp_cnt & 32'hFF);
            chk("halt_data", {24'd0, wb_data}, 32'hFF);
        end
        instr_valid = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
